// File: rtl/regfile_mem_engine_if.sv
// Bus/request bundle for regfile_mem_engine.
// master: the engine side (drives bus address/data, register-file strobes, status).
// slave : the CPU / memory / register-file side.
interface regfile_mem_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4
);
  logic              start;
  logic [1:0]        op;
  logic [IDX_W-1:0]  last_idx;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        cu_state;
  logic [IDX_W-1:0]  rf_rd_idx;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [IDX_W-1:0]  rf_wr_idx;
  logic [DATA_W-1:0] rf_wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] i_out;

  modport master (
    input  start, op, last_idx, base_addr, data_in, rf_rd_data,
    output data_out, addr, cu_state, rf_rd_idx, rf_wr_en, rf_wr_idx,
           rf_wr_data, busy, done, error, i_out
  );

  modport slave (
    output start, op, last_idx, base_addr, data_in, rf_rd_data,
    input  data_out, addr, cu_state, rf_rd_idx, rf_wr_en, rf_wr_idx,
           rf_wr_data, busy, done, error, i_out
  );
endinterface

// File: rtl/regfile_mem_engine.sv
// Register-file / memory bulk transfer sequencer: STORE V0..Vx, LOAD V0..Vx,
// BCD-serialise one register. Optional macro I_INCREMENT_EN makes STORE/LOAD
// report i_out = base+N instead of base.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start
// S_STORE  | writing rf[k] to base+k, k = 0..last
// S_LOAD   | reading base+k; rf write of the previous read lags one cycle
// S_BCD    | writing hundreds/tens/ones digit to base+0/1/2
// S_FINISH | done pulse (error too if the request was rejected); accepts start
module regfile_mem_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic clk,
  input  logic reset,
  regfile_mem_engine_if.master bus
);

  localparam logic [1:0] CU_DIS = 2'b00;
  localparam logic [1:0] CU_RD  = 2'b01;
  localparam logic [1:0] CU_WR  = 2'b10;
  localparam int         VW     = DATA_W + 8;

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_LOAD, S_BCD, S_FINISH} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  last_q, k_q, wr_idx_q;
  logic [ADDR_W-1:0] base_q, i_q, i_next;
  logic [DATA_W-1:0] v_q, digit;
  logic              err_q, wr_pend_q;
  logic              accept, req_err;
  logic [VW-1:0]     v_ext, d_hund, d_tens, d_ones;

  logic [1:0]        cu_state_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_out_c;
  logic [IDX_W-1:0]  rf_rd_idx_c;
  logic              busy_c, done_c, error_c;

  assign accept  = bus.start && (state == S_IDLE || state == S_FINISH);
  assign req_err = (bus.op == 2'b11) || (32'(bus.last_idx) >= NUM_REGS);

`ifdef I_INCREMENT_EN
  assign i_next = (!req_err && bus.op != 2'b10)
                ? bus.base_addr + ADDR_W'(bus.last_idx) + ADDR_W'(1)
                : bus.base_addr;
`else
  assign i_next = bus.base_addr;
`endif

  assign v_ext  = {8'd0, v_q};
  assign d_hund = v_ext / VW'(100);
  assign d_tens = (v_ext / VW'(10)) % VW'(10);
  assign d_ones = v_ext % VW'(10);

  // Digit selected by the BCD step counter.
  always_comb begin
    digit = DATA_W'(d_ones);
    case (k_q[1:0])
      2'd0:    digit = DATA_W'(d_hund);
      2'd1:    digit = DATA_W'(d_tens);
      default: digit = DATA_W'(d_ones);
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and bus/status outputs.
  always_comb begin
    state_nx    = state;
    cu_state_c  = CU_DIS;
    addr_c      = '0;
    data_out_c  = '0;
    rf_rd_idx_c = bus.last_idx;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    error_c     = 1'b0;
    case (state)
      S_IDLE, S_FINISH: begin
        if (state == S_FINISH) begin
          done_c  = 1'b1;
          error_c = err_q;
        end
        state_nx = S_IDLE;
        if (bus.start) begin
          if (req_err)               state_nx = S_FINISH;
          else if (bus.op == 2'b00)  state_nx = S_STORE;
          else if (bus.op == 2'b01)  state_nx = S_LOAD;
          else                       state_nx = S_BCD;
        end
      end
      S_STORE: begin
        cu_state_c  = CU_WR;
        addr_c      = base_q + ADDR_W'(k_q);
        rf_rd_idx_c = k_q;
        data_out_c  = bus.rf_rd_data;
        busy_c      = 1'b1;
        if (k_q == last_q) state_nx = S_FINISH;
      end
      S_LOAD: begin
        cu_state_c = CU_RD;
        addr_c     = base_q + ADDR_W'(k_q);
        busy_c     = 1'b1;
        if (k_q == last_q) state_nx = S_FINISH;
      end
      S_BCD: begin
        cu_state_c = CU_WR;
        addr_c     = base_q + ADDR_W'(k_q);
        data_out_c = digit;
        busy_c     = 1'b1;
        if (k_q == IDX_W'(2)) state_nx = S_FINISH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, step counter, delayed LOAD write strobe and final index.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= '0;
      base_q    <= '0;
      v_q       <= '0;
      err_q     <= 1'b0;
      k_q       <= '0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      i_q       <= '0;
    end else begin
      wr_pend_q <= (state == S_LOAD);
      wr_idx_q  <= k_q;
      if (accept) begin
        last_q <= bus.last_idx;
        base_q <= bus.base_addr;
        v_q    <= bus.rf_rd_data;
        err_q  <= req_err;
        k_q    <= '0;
        i_q    <= i_next;
      end else if (state == S_STORE || state == S_LOAD || state == S_BCD) begin
        k_q <= k_q + IDX_W'(1);
      end
    end
  end

  assign bus.cu_state   = cu_state_c;
  assign bus.addr       = addr_c;
  assign bus.data_out   = data_out_c;
  assign bus.rf_rd_idx  = rf_rd_idx_c;
  assign bus.rf_wr_en   = wr_pend_q;
  assign bus.rf_wr_idx  = wr_idx_q;
  assign bus.rf_wr_data = bus.data_in;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.error      = error_c;
  assign bus.i_out      = i_q;

endmodule

// File: tb/tb_regfile_mem_engine.sv
// Scoreboard bench for regfile_mem_engine (NUM_REGS=12 so index errors are reachable).
module tb_regfile_mem_engine;
  localparam int DW = 8, AW = 16, NR = 12, IW = 4;
`ifdef I_INCREMENT_EN
  localparam bit INC = 1'b1;
`else
  localparam bit INC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_mem_engine_if #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) bus_if ();
  regfile_mem_engine #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus_if));

  typedef struct { int cyc; logic [15:0] a; logic [7:0] d; } ev_t;
  typedef struct { int cyc; logic err; logic [AW-1:0] iout; } done_t;

  ev_t   q_wr[$], q_rd[$], q_rf[$];
  done_t q_done[$];

  int checks = 0, failures = 0;
  int cyc_cnt = 0, acc_cyc = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] rf [16];
  logic [7:0] mem [logic [15:0]];
  logic rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  assign bus_if.rf_rd_data = rf[bus_if.rf_rd_idx];

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt++;

  // Memory: data for a READ_ENABLE cycle appears in the following cycle.
  always @(negedge clk) begin
    rd_pend = (bus_if.cu_state == 2'b01);
    rd_addr = bus_if.addr;
  end
  always @(posedge clk) begin
    #1;
    bus_if.data_in = rd_pend ? mem_rd(rd_addr) : 8'h00;
  end

  // Monitor: pops the expected event for every output the DUT presents.
  always @(negedge clk) begin
    int c;
    ev_t e;
    done_t dn;
    if (mon_en) begin
      c = cyc_cnt - acc_cyc + 1;
      if (bus_if.cu_state == 2'b10) begin
        if (q_wr.size() == 0) chk("unexpected_write", {16'(c), bus_if.addr, bus_if.data_out}, 64'h0);
        else begin
          e = q_wr.pop_front();
          chk("bus_write", {16'(c), bus_if.addr, bus_if.data_out}, {16'(e.cyc), e.a, e.d});
        end
      end
      if (bus_if.cu_state == 2'b01) begin
        if (q_rd.size() == 0) chk("unexpected_read", {16'(c), bus_if.addr}, 64'h0);
        else begin
          e = q_rd.pop_front();
          chk("bus_read", {16'(c), bus_if.addr}, {16'(e.cyc), e.a});
        end
      end
      if (bus_if.cu_state == 2'b11) chk("cu_state_illegal", 64'(bus_if.cu_state), 64'h0);
      if (bus_if.rf_wr_en) begin
        if (q_rf.size() == 0) chk("unexpected_rf_write", {16'(c), 16'(bus_if.rf_wr_idx), bus_if.rf_wr_data}, 64'h0);
        else begin
          e = q_rf.pop_front();
          chk("rf_write", {16'(c), 16'(bus_if.rf_wr_idx), bus_if.rf_wr_data}, {16'(e.cyc), e.a, e.d});
        end
      end
      if (bus_if.error && !bus_if.done) chk("error_without_done", 64'h1, 64'h0);
      if (bus_if.done) begin
        if (q_done.size() == 0) chk("unexpected_done", {16'(c), 8'(bus_if.error), bus_if.i_out}, 64'h0);
        else begin
          dn = q_done.pop_front();
          chk("done", {16'(c), 8'(bus_if.error), bus_if.i_out}, {16'(dn.cyc), 8'(dn.err), dn.iout});
          chk("busy_at_done", 64'(bus_if.busy), 64'h0);
        end
      end
    end
  end

  task automatic push_ev(input int which, input int c, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc = c; e.a = a; e.d = d;
    if (which == 0) q_wr.push_back(e);
    else if (which == 1) q_rd.push_back(e);
    else q_rf.push_back(e);
  endtask

  task automatic push_done(input int c, input logic err, input logic [AW-1:0] iout);
    done_t dn;
    dn.cyc = c; dn.err = err; dn.iout = iout;
    q_done.push_back(dn);
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] li, input logic [15:0] base);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = op; bus_if.last_idx = li; bus_if.base_addr = base;
    @(posedge clk);
    #1;
    acc_cyc = cyc_cnt;
    bus_if.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [3:0] li,
                        input logic [15:0] base, input bit err, input bit spurious);
    int pend;
    issue(op, li, base);
    chk({name, "_busy_c1"}, 64'(bus_if.busy), 64'(!err));
    if (spurious) begin
      @(negedge clk);
      bus_if.start = 1'b1; bus_if.op = 2'b01; bus_if.last_idx = 4'd9; bus_if.base_addr = 16'h1234;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
    end
    for (int n = 0; n < 40; n++) begin
      pend = q_wr.size() + q_rd.size() + q_rf.size() + q_done.size();
      if (pend == 0) break;
      @(negedge clk);
      #2;
    end
    pend = q_wr.size() + q_rd.size() + q_rf.size() + q_done.size();
    chk({name, "_drained"}, 64'(pend), 64'h0);
    q_wr.delete(); q_rd.delete(); q_rf.delete(); q_done.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33;
    rf[5] = 8'd254; rf[6] = 8'd7; rf[7] = 8'd100;
    for (int i = 0; i < 4; i++) mem[16'h0400 + 16'(i)] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) mem[16'h0900 + 16'(i)] = 8'hB0 + 8'(i);
    bus_if.start = 1'b0; bus_if.op = 2'b00; bus_if.last_idx = '0; bus_if.base_addr = '0;
    bus_if.data_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cu_state", 64'(bus_if.cu_state), 64'h0);
    chk("rst_addr_data", {bus_if.addr, bus_if.data_out}, 64'h0);
    chk("rst_status", {bus_if.busy, bus_if.done, bus_if.error, bus_if.rf_wr_en}, 64'h0);
    chk("rst_i_out", 64'(bus_if.i_out), 64'h0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // STORE V0..V2 to 0x0300, with an ignored start while busy.
    push_ev(0, 1, 16'h0300, 8'h11); push_ev(0, 2, 16'h0301, 8'h22); push_ev(0, 3, 16'h0302, 8'h33);
    push_done(4, 1'b0, INC ? 16'h0303 : 16'h0300);
    run_op("store3", 2'b00, 4'd2, 16'h0300, 1'b0, 1'b1);

    // LOAD V0..V3 from 0x0400.
    for (int k = 0; k < 4; k++) begin
      push_ev(1, k + 1, 16'h0400 + 16'(k), 8'h00);
      push_ev(2, k + 2, 16'(k), 8'hA0 + 8'(k));
    end
    push_done(5, 1'b0, INC ? 16'h0404 : 16'h0400);
    run_op("load4", 2'b01, 4'd3, 16'h0400, 1'b0, 1'b0);

    // BCD of 254, 7 and 100.
    push_ev(0, 1, 16'h0500, 8'd2); push_ev(0, 2, 16'h0501, 8'd5); push_ev(0, 3, 16'h0502, 8'd4);
    push_done(4, 1'b0, 16'h0500);
    run_op("bcd254", 2'b10, 4'd5, 16'h0500, 1'b0, 1'b0);
    push_ev(0, 1, 16'h0510, 8'd0); push_ev(0, 2, 16'h0511, 8'd0); push_ev(0, 3, 16'h0512, 8'd7);
    push_done(4, 1'b0, 16'h0510);
    run_op("bcd7", 2'b10, 4'd6, 16'h0510, 1'b0, 1'b0);
    push_ev(0, 1, 16'h0520, 8'd1); push_ev(0, 2, 16'h0521, 8'd0); push_ev(0, 3, 16'h0522, 8'd0);
    push_done(4, 1'b0, 16'h0520);
    run_op("bcd100", 2'b10, 4'd7, 16'h0520, 1'b0, 1'b0);

    // STORE across the address wrap.
    push_ev(0, 1, 16'hFFFF, 8'h11); push_ev(0, 2, 16'h0000, 8'h22);
    push_done(3, 1'b0, INC ? 16'h0001 : 16'hFFFF);
    run_op("store_wrap", 2'b00, 4'd1, 16'hFFFF, 1'b0, 1'b0);

    // Rejected requests.
    push_done(1, 1'b1, 16'h0600);
    run_op("err_op11", 2'b11, 4'd2, 16'h0600, 1'b1, 1'b0);
    push_done(1, 1'b1, 16'h0700);
    run_op("err_idx13", 2'b00, 4'd13, 16'h0700, 1'b1, 1'b0);

    // Reset during cycle 2 of LOAD last_idx=5.
    push_ev(1, 1, 16'h0900, 8'h00); push_ev(1, 2, 16'h0901, 8'h00);
    push_ev(2, 2, 16'h0000, 8'hB0);
    issue(2'b01, 4'd5, 16'h0900);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_status", {bus_if.cu_state, bus_if.busy, bus_if.done}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("midrst_drained", 64'(q_wr.size() + q_rd.size() + q_rf.size() + q_done.size()), 64'h0);
    q_wr.delete(); q_rd.delete(); q_rf.delete(); q_done.delete();

    // Single-register STORE after recovery.
    push_ev(0, 1, 16'h0800, 8'h11);
    push_done(2, 1'b0, INC ? 16'h0801 : 16'h0800);
    run_op("store1", 2'b00, 4'd0, 16'h0800, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
